// File: rtl/dest_sel_pipe.sv
// Destination-register select and in-flight tracking pipeline with
// source-operand hazard detection against every valid stage.
module dest_sel_pipe #(
   parameter int W     = 5,
   parameter int N     = 4,
   parameter int DEPTH = 3
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic [N*W-1:0]                              data_in,
   input  logic [$clog2(N)-1:0]                        pos,
   input  logic                                        valid_in,
   input  logic                                        stall,
   input  logic                                        flush,
   input  logic [W-1:0]                                rs_addr,
   input  logic [W-1:0]                                rt_addr,
   output logic [W-1:0]                                data,
   output logic                                        valid_out,
   output logic [DEPTH*W-1:0]                          stage_addr,
   output logic [DEPTH-1:0]                            stage_valid,
   output logic                                        hazard_rs,
   output logic                                        hazard_rt,
   output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] rs_dist,
   output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] rt_dist
);

   localparam int PW = $clog2(N);
   localparam int DW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]     r_addr [DEPTH];
   logic [DEPTH-1:0] r_valid;
   logic [W-1:0]     w_sel;
   logic             w_sel_ok;

   // Out-of-range selects produce address 0 and are captured as invalid.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_sel    = '0;
      w_sel_ok = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (pos == PW'(i)) begin
            w_sel    = data_in[i*W +: W];
            w_sel_ok = 1'b1;
         end
      end
   end

   // NOTE: the stage array is small, so addresses are reset too; this keeps data=0 in reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            r_addr[k] <= '0;
         end
         r_valid <= '0;
      end else if (flush) begin
         r_valid <= '0;
      end else if (!stall) begin
         r_addr[0]  <= w_sel;
         r_valid[0] <= valid_in & w_sel_ok;
         for (int k = 1; k < DEPTH; k++) begin
            r_addr[k]  <= r_addr[k-1];
            r_valid[k] <= r_valid[k-1];
         end
      end
   end

   always_comb begin
      stage_addr = '0;
      for (int k = 0; k < DEPTH; k++) begin
         stage_addr[k*W +: W] = r_addr[k];
      end
   end

   assign stage_valid = r_valid;
   assign data        = r_addr[DEPTH-1];
   assign valid_out   = r_valid[DEPTH-1];

   // Scan from the oldest stage down so the nearest (lowest) match wins.
   always_comb begin
      hazard_rs = 1'b0;
      hazard_rt = 1'b0;
      rs_dist   = '0;
      rt_dist   = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (r_valid[k] && (r_addr[k] == rs_addr) && (rs_addr != '0)) begin
            hazard_rs = 1'b1;
            rs_dist   = DW'(k);
         end
         if (r_valid[k] && (r_addr[k] == rt_addr) && (rt_addr != '0)) begin
            hazard_rt = 1'b1;
            rt_dist   = DW'(k);
         end
      end
   end

endmodule

// File: tb/tb_dest_sel_pipe.sv
// Scoreboard bench for dest_sel_pipe: default instance plus an N=3 instance
// for the out-of-range select case.
module tb_dest_sel_pipe;

   localparam int W     = 5;
   localparam int N     = 4;
   localparam int DEPTH = 3;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N*W-1:0] data_in = '0;
   logic [1:0]     pos = '0;
   logic           valid_in = 1'b0;
   logic           stall = 1'b0;
   logic           flush = 1'b0;
   logic [W-1:0]   rs_addr = '0;
   logic [W-1:0]   rt_addr = '0;
   logic [W-1:0]   data;
   logic           valid_out;
   logic [DEPTH*W-1:0] stage_addr;
   logic [DEPTH-1:0]   stage_valid;
   logic           hazard_rs, hazard_rt;
   logic [1:0]     rs_dist, rt_dist;

   logic [3*W-1:0] data_in3 = '0;
   logic [1:0]     pos3 = '0;
   logic           valid_in3 = 1'b0;
   logic [W-1:0]   data3;
   logic           valid_out3;
   logic [DEPTH*W-1:0] stage_addr3;
   logic [DEPTH-1:0]   stage_valid3;
   logic           hazard_rs3, hazard_rt3;
   logic [1:0]     rs_dist3, rt_dist3;

   int checks = 0;
   int passes = 0;
   logic [W-1:0] sb[$];

   always #5 clk = ~clk;

   dest_sel_pipe #(.W(W), .N(N), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .pos(pos), .valid_in(valid_in),
      .stall(stall), .flush(flush), .rs_addr(rs_addr), .rt_addr(rt_addr),
      .data(data), .valid_out(valid_out), .stage_addr(stage_addr),
      .stage_valid(stage_valid), .hazard_rs(hazard_rs), .hazard_rt(hazard_rt),
      .rs_dist(rs_dist), .rt_dist(rt_dist)
   );

   dest_sel_pipe #(.W(W), .N(3), .DEPTH(DEPTH)) dut3 (
      .clk(clk), .rst(rst), .data_in(data_in3), .pos(pos3), .valid_in(valid_in3),
      .stall(stall), .flush(flush), .rs_addr(rs_addr), .rt_addr(rt_addr),
      .data(data3), .valid_out(valid_out3), .stage_addr(stage_addr3),
      .stage_valid(stage_valid3), .hazard_rs(hazard_rs3), .hazard_rt(hazard_rt3),
      .rs_dist(rs_dist3), .rt_dist(rt_dist3)
   );

   // Retire the leaving entry, record the entering one, then advance one edge.
   task automatic step();
      logic [W-1:0] exp_addr;
      if (!rst && !flush && !stall && valid_out) begin
         checks++;
         if (sb.size() == 0) begin
            $display("FAIL sb_unexpected: got data=%0d valid_out=1, expected no entry", data);
         end else begin
            exp_addr = sb.pop_front();
            if (data !== exp_addr) $display("FAIL sb_data: got %0d expected %0d", data, exp_addr);
            else passes++;
         end
      end
      if (rst || flush) sb.delete();
      else if (!stall && valid_in) sb.push_back(data_in[pos*W +: W]);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rs_addr = 5'd9;
      rt_addr = 5'd9;
      #1;
      checks++; if (data !== 5'd0) $display("FAIL rst_data: got %0d expected 0", data); else passes++;
      checks++; if (valid_out !== 1'b0) $display("FAIL rst_valid_out: got %b expected 0", valid_out); else passes++;
      checks++; if (stage_valid !== 3'b000) $display("FAIL rst_stage_valid: got %b expected 000", stage_valid); else passes++;
      checks++; if (stage_addr !== 15'd0) $display("FAIL rst_stage_addr: got %h expected 0", stage_addr); else passes++;
      checks++; if ({hazard_rs, hazard_rt, rs_dist, rt_dist} !== 6'd0)
         $display("FAIL rst_hazard: got %b%b %0d %0d expected all 0", hazard_rs, hazard_rt, rs_dist, rt_dist);
      else passes++;
      @(posedge clk);
      #1;
      rst = 1'b0;
      rs_addr = '0;
      rt_addr = '0;
      checks++; if ({valid_out, stage_valid} !== 4'd0) $display("FAIL post_rst_valid: got %b%b expected 0", valid_out, stage_valid); else passes++;
   endtask

   task automatic test_single();
      data_in  = {5'd20, 5'd17, 5'd11, 5'd6};
      pos      = 2'd2;
      valid_in = 1'b1;
      step();
      checks++; if (stage_addr[4:0] !== 5'd17) $display("FAIL single_stage0: got %0d expected 17", stage_addr[4:0]); else passes++;
      checks++; if (stage_valid !== 3'b001) $display("FAIL single_v1: got %b expected 001", stage_valid); else passes++;
      valid_in = 1'b0;
      pos      = 2'd0;
      step();
      checks++; if (stage_valid !== 3'b010) $display("FAIL single_v2: got %b expected 010", stage_valid); else passes++;
      step();
      checks++; if (valid_out !== 1'b1 || data !== 5'd17)
         $display("FAIL single_out: got valid_out=%b data=%0d expected 1/17", valid_out, data);
      else passes++;
      step();
      checks++; if (valid_out !== 1'b0) $display("FAIL single_once: got valid_out=%b expected 0", valid_out); else passes++;
      checks++; if (sb.size() != 0) $display("FAIL single_drain: got %0d pending expected 0", sb.size()); else passes++;
   endtask

   task automatic test_stall();
      data_in  = {5'd20, 5'd17, 5'd11, 5'd6};
      pos      = 2'd2;
      valid_in = 1'b1;
      step();
      valid_in = 1'b0;
      pos      = 2'd0;
      stall    = 1'b1;
      step();
      checks++; if (stage_valid !== 3'b001 || stage_addr[4:0] !== 5'd17)
         $display("FAIL stall_hold: got v=%b a0=%0d expected 001/17", stage_valid, stage_addr[4:0]);
      else passes++;
      step();
      checks++; if (stage_valid !== 3'b001 || valid_out !== 1'b0)
         $display("FAIL stall_hold2: got v=%b expected 001", stage_valid);
      else passes++;
      stall = 1'b0;
      step();
      checks++; if (stage_valid !== 3'b010) $display("FAIL stall_e4: got %b expected 010", stage_valid); else passes++;
      step();
      checks++; if (valid_out !== 1'b1 || data !== 5'd17)
         $display("FAIL stall_out: got valid_out=%b data=%0d expected 1/17", valid_out, data);
      else passes++;
      step();
      checks++; if (valid_out !== 1'b0) $display("FAIL stall_once: got %b expected 0", valid_out); else passes++;
      checks++; if (sb.size() != 0) $display("FAIL stall_drain: got %0d pending expected 0", sb.size()); else passes++;
   endtask

   task automatic test_hazard();
      data_in  = {5'd12, 5'd7, 5'd0, 5'd9};
      valid_in = 1'b1;
      pos      = 2'd0;
      step();
      step();
      pos = 2'd1;
      step();
      rs_addr = 5'd9;
      rt_addr = 5'd0;
      #1;
      checks++; if (hazard_rs !== 1'b1 || rs_dist !== 2'd1)
         $display("FAIL haz_rs: got %b/%0d expected 1/1", hazard_rs, rs_dist);
      else passes++;
      checks++; if (hazard_rt !== 1'b0 || rt_dist !== 2'd0)
         $display("FAIL haz_rt_zero: got %b/%0d expected 0/0", hazard_rt, rt_dist);
      else passes++;
      rs_addr = 5'd7;
      rt_addr = 5'd9;
      #1;
      checks++; if (hazard_rs !== 1'b0 || hazard_rt !== 1'b1 || rt_dist !== 2'd1)
         $display("FAIL haz_rt: got rs=%b rt=%b/%0d expected 0 1/1", hazard_rs, hazard_rt, rt_dist);
      else passes++;
      valid_in = 1'b0;
      stall    = 1'b1;
      step();
      checks++; if (hazard_rt !== 1'b1 || rt_dist !== 2'd1)
         $display("FAIL haz_stall: got %b/%0d expected 1/1", hazard_rt, rt_dist);
      else passes++;
      stall = 1'b0;
      pos   = 2'd0;
      step();
      rs_addr = 5'd9;
      #1;
      checks++; if (hazard_rs !== 1'b1 || rs_dist !== 2'd2)
         $display("FAIL haz_far: got %b/%0d expected 1/2", hazard_rs, rs_dist);
      else passes++;
      rs_addr = 5'd0;
      #1;
      checks++; if (hazard_rs !== 1'b0) $display("FAIL haz_r0: got %b expected 0", hazard_rs); else passes++;
      rt_addr = 5'd0;
      step();
      step();
      step();
      checks++; if (sb.size() != 0) $display("FAIL haz_drain: got %0d pending expected 0", sb.size()); else passes++;
   endtask

   task automatic test_flush();
      data_in  = {5'd5, 5'd4, 5'd3, 5'd0};
      valid_in = 1'b1;
      pos = 2'd1; step();
      pos = 2'd2; step();
      pos = 2'd3; step();
      checks++; if (stage_valid !== 3'b111) $display("FAIL flush_load: got %b expected 111", stage_valid); else passes++;
      valid_in = 1'b0;
      rs_addr  = 5'd4;
      rt_addr  = 5'd3;
      flush    = 1'b1;
      stall    = 1'b1;
      step();
      flush = 1'b0;
      stall = 1'b0;
      checks++; if (stage_valid !== 3'b000 || valid_out !== 1'b0)
         $display("FAIL flush_valid: got %b/%b expected 000/0", stage_valid, valid_out);
      else passes++;
      checks++; if (hazard_rs !== 1'b0 || hazard_rt !== 1'b0)
         $display("FAIL flush_hazard: got %b%b expected 00", hazard_rs, hazard_rt);
      else passes++;
      checks++; if (stage_addr !== {5'd3, 5'd4, 5'd5})
         $display("FAIL flush_addr_hold: got %h expected %h", stage_addr, {5'd3, 5'd4, 5'd5});
      else passes++;
      rs_addr = '0;
      rt_addr = '0;
   endtask

   task automatic test_rst_mid();
      data_in  = {5'd5, 5'd4, 5'd3, 5'd0};
      valid_in = 1'b1;
      pos = 2'd1; step();
      pos = 2'd2; step();
      valid_in = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks++; if (stage_valid !== 3'b000 || valid_out !== 1'b0)
         $display("FAIL rstmid_valid: got %b/%b expected 000/0", stage_valid, valid_out);
      else passes++;
      checks++; if (data !== 5'd0 || stage_addr !== 15'd0)
         $display("FAIL rstmid_addr: got data=%0d addr=%h expected 0", data, stage_addr);
      else passes++;
      #1 rst = 1'b0;
      sb.delete();
      valid_in = 1'b1;
      pos      = 2'd3;
      step();
      checks++; if (stage_addr[4:0] !== 5'd5 || stage_valid !== 3'b001)
         $display("FAIL rstmid_first: got %0d/%b expected 5/001", stage_addr[4:0], stage_valid);
      else passes++;
      valid_in = 1'b0;
      step();
      step();
      step();
      checks++; if (sb.size() != 0) $display("FAIL rstmid_drain: got %0d pending expected 0", sb.size()); else passes++;
   endtask

   task automatic test_n3_range();
      data_in3  = {5'd21, 5'd22, 5'd23};
      pos3      = 2'd3;
      valid_in3 = 1'b1;
      step();
      checks++; if (stage_valid3[0] !== 1'b0 || stage_addr3[4:0] !== 5'd0)
         $display("FAIL n3_oor: got v=%b a=%0d expected 0/0", stage_valid3[0], stage_addr3[4:0]);
      else passes++;
      valid_in3 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if (valid_out3 !== 1'b0) $display("FAIL n3_no_out: got %b expected 0 (edge %0d)", valid_out3, i); else passes++;
      end
      pos3      = 2'd1;
      valid_in3 = 1'b1;
      step();
      valid_in3 = 1'b0;
      step();
      step();
      checks++; if (valid_out3 !== 1'b1 || data3 !== 5'd22)
         $display("FAIL n3_inrange: got %b/%0d expected 1/22", valid_out3, data3);
      else passes++;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 24; i++) begin
         data_in  = 20'($urandom);
         pos      = 2'($urandom_range(0, 3));
         valid_in = ($urandom_range(0, 3) != 0);
         stall    = ($urandom_range(0, 4) == 0);
         step();
      end
      valid_in = 1'b0;
      stall    = 1'b0;
      for (int i = 0; i < 10 && sb.size() > 0; i++) step();
      checks++; if (sb.size() != 0) $display("FAIL b2b_drain: got %0d pending expected 0", sb.size()); else passes++;
      checks++; if (stage_valid !== 3'b000) $display("FAIL b2b_empty: got %b expected 000", stage_valid); else passes++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_stall();
      test_hazard();
      test_flush();
      test_rst_mid();
      test_n3_range();
      test_back_to_back();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
